// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared widths and rounding helper for FFT output streams
//
// Purpose: default component widths/frame sizes and the round-half-to-even
//          with positive clamp used when narrowing FFT output components.
// Layout : a complex sample is {real, imag}; real occupies the upper half.

package fft_stream_pkg;

   localparam int IWIDTH_DEF = 21;
   localparam int OWIDTH_DEF = 16;
   localparam int LGSIZE_DEF = 11;
   localparam int LGFIFO_DEF = 5;

   // Drops 'drop' LSBs from a sign-extended value, rounding half to even.
   // Only a positive carry can leave the 'ow'-bit range, so only the top clamps.
   function automatic logic signed [63:0] round_half_even(
      input logic signed [63:0] x,
      input int                 drop,
      input int                 ow
   );
      logic signed [63:0] t;
      logic signed [63:0] rem;
      logic signed [63:0] half;
      logic signed [63:0] r;
      logic signed [63:0] maxv;
      t    = x >>> drop;
      rem  = x - (t <<< drop);
      half = 64'sd1 <<< (drop - 1);
      r    = t;
      if ((rem > half) || ((rem == half) && t[0]))
         r = t + 64'sd1;
      maxv = (64'sd1 <<< (ow - 1)) - 64'sd1;
      if (r > maxv)
         r = maxv;
      return r;
   endfunction

endpackage

// File: rtl/sfifo.sv
// rtl/sfifo.sv - synchronous show-ahead FIFO
//
// Purpose: single-clock FIFO of 2^LGFLEN words; o_data shows the head word.
// Ports  : i_clk, i_reset (sync, active-high), i_wr/i_data push,
//          i_rd pop, o_empty, o_full, o_data (head word).
//          A write while full is accepted only together with a read.

module sfifo #(
   parameter int BW     = 8,
   parameter int LGFLEN = 5
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_wr,
   input  logic [BW-1:0] i_data,
   input  logic          i_rd,
   output logic          o_empty,
   output logic          o_full,
   output logic [BW-1:0] o_data
);

   logic [BW-1:0]   r_mem [0:(1<<LGFLEN)-1];
   logic [LGFLEN:0] r_wptr;
   logic [LGFLEN:0] r_rptr;
   logic            w_do_wr;
   logic            w_do_rd;

   // Extra pointer MSB distinguishes full from empty.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[LGFLEN] != r_rptr[LGFLEN]) &&
                    (r_wptr[LGFLEN-1:0] == r_rptr[LGFLEN-1:0]);
   assign w_do_rd = i_rd && !o_empty;
   assign w_do_wr = i_wr && (!o_full || w_do_rd);
   assign o_data  = r_mem[r_rptr[LGFLEN-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_do_wr)
         r_mem[r_wptr[LGFLEN-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_do_rd)
            r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: rtl/fft_pair_serializer.sv
// rtl/fft_pair_serializer.sv - serializes rounded FFT output pairs onto a valid/ready stream
//
// Purpose: locks to the FFT frame sync, rounds each component IWIDTH->OWIDTH,
//          buffers pairs in a FIFO and emits one complex sample per beat with
//          frame first/last flags.
// Ports  : i_clk, i_reset (sync, active-high)
//          i_ce, i_left, i_right, i_sync      - input pair stream {real,imag}
//          o_valid, i_ready, o_data           - output sample stream {real,imag}
//          o_first, o_last                    - frame sample 0 / 2^LGSIZE-1
//          o_locked                           - first sync seen
//          o_overflow                         - sticky, a pair was dropped

module fft_pair_serializer
   import fft_stream_pkg::*;
#(
   parameter int IWIDTH = IWIDTH_DEF,
   parameter int OWIDTH = OWIDTH_DEF,
   parameter int LGSIZE = LGSIZE_DEF,
   parameter int LGFIFO = LGFIFO_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_ce,
   input  logic [2*IWIDTH-1:0] i_left,
   input  logic [2*IWIDTH-1:0] i_right,
   input  logic                i_sync,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [2*OWIDTH-1:0] o_data,
   output logic                o_first,
   output logic                o_last,
   output logic                o_locked,
   output logic                o_overflow
);

   localparam int                EW      = 4*OWIDTH + 1;
   localparam logic [LGSIZE-1:0] CNT_MAX = '1;

   function automatic logic [OWIDTH-1:0] rnd(input logic [IWIDTH-1:0] c);
      logic signed [63:0] r;
      r = round_half_even(64'(signed'(c)), IWIDTH - OWIDTH, OWIDTH);
      return r[OWIDTH-1:0];
   endfunction

   logic                r_locked;
   logic                r_rvalid;
   logic                r_rsync;
   logic [2*OWIDTH-1:0] r_rleft;
   logic [2*OWIDTH-1:0] r_rright;
   logic                r_overflow;
   logic                r_valid;
   logic                r_half;
   logic [2*OWIDTH-1:0] r_right;
   logic [LGSIZE-1:0]   r_count;

   logic                w_accept;
   logic                w_wr;
   logic                w_rd;
   logic                w_empty;
   logic                w_full;
   logic [EW-1:0]       w_fifo_q;
   logic                w_beat;
   logic                w_load;
   logic [LGSIZE-1:0]   w_cnt_next;

   assign w_accept   = i_ce && (i_sync || r_locked);
   assign w_beat     = r_valid && i_ready;
   // Load when idle, or when the right half is leaving on this beat.
   assign w_load     = !w_empty && (!r_valid || (w_beat && r_half));
   assign w_rd       = w_load;
   assign w_wr       = r_rvalid && (!w_full || w_rd);
   assign w_cnt_next = r_count + 1'b1;

   assign o_valid    = r_valid;
   assign o_locked   = r_locked;
   assign o_overflow = r_overflow;

   // Lock, rounding stage and sticky overflow.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_locked   <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rsync    <= 1'b0;
         r_rleft    <= '0;
         r_rright   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_ce && i_sync)
            r_locked <= 1'b1;
         r_rvalid <= w_accept;
         if (w_accept) begin
            r_rsync  <= i_sync;
            r_rleft  <= {rnd(i_left[2*IWIDTH-1:IWIDTH]),  rnd(i_left[IWIDTH-1:0])};
            r_rright <= {rnd(i_right[2*IWIDTH-1:IWIDTH]), rnd(i_right[IWIDTH-1:0])};
         end
         if (r_rvalid && w_full && !w_rd)
            r_overflow <= 1'b1;
      end
   end

   sfifo #(
      .BW     (EW),
      .LGFLEN (LGFIFO)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_wr    (w_wr),
      .i_data  ({r_rsync, r_rleft, r_rright}),
      .i_rd    (w_rd),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_data  (w_fifo_q)
   );

   // Output stage: left half on load, right half after the left beat.
   // r_count is the frame index of the sample currently on o_data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_half  <= 1'b0;
         r_right <= '0;
         r_count <= '0;
         o_data  <= '0;
         o_first <= 1'b0;
         o_last  <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_half  <= 1'b0;
         o_data  <= w_fifo_q[4*OWIDTH-1:2*OWIDTH];
         r_right <= w_fifo_q[2*OWIDTH-1:0];
         if (w_fifo_q[EW-1]) begin
            // Tagged entry resynchronizes the frame after any drops.
            r_count <= '0;
            o_first <= 1'b1;
            o_last  <= 1'b0;
         end else begin
            r_count <= w_cnt_next;
            o_first <= 1'b0;
            o_last  <= (w_cnt_next == CNT_MAX);
         end
      end else if (w_beat) begin
         if (!r_half) begin
            r_half  <= 1'b1;
            o_data  <= r_right;
            r_count <= w_cnt_next;
            o_first <= 1'b0;
            o_last  <= (w_cnt_next == CNT_MAX);
         end else begin
            r_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_pair_serializer.sv
// tb/tb_fft_pair_serializer.sv - self-checking bench for fft_pair_serializer

module tb_fft_pair_serializer;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_ce;
   logic [41:0] i_left;
   logic [41:0] i_right;
   logic        i_sync;
   logic        i_ready;
   logic        o_valid;
   logic [31:0] o_data;
   logic        o_first;
   logic        o_last;
   logic        o_locked;
   logic        o_overflow;

   int n_err = 0;
   int n_chk = 0;

   // Entries are {sample[31:0], first, last}.
   logic [33:0] exp_q[$];
   logic [33:0] obs_q[$];
   bit          m_locked;
   int          m_idx;

   fft_pair_serializer dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_ce       (i_ce),
      .i_left     (i_left),
      .i_right    (i_right),
      .i_sync     (i_sync),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_first    (o_first),
      .o_last     (o_last),
      .o_locked   (o_locked),
      .o_overflow (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk)
      if (!i_reset && o_valid && i_ready)
         obs_q.push_back({o_data, o_first, o_last});

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Reference rounding: floor divide by 32, then round half to even, clamp top.
   function automatic logic [15:0] ref_round(input logic [20:0] c);
      int v, fl, rem;
      v  = int'(signed'(c));
      fl = (v >= 0) ? v / 32 : -((-v + 31) / 32);
      rem = v - fl * 32;
      if (rem > 16 || (rem == 16 && (fl % 2) != 0))
         fl = fl + 1;
      if (fl > 32767)
         fl = 32767;
      return 16'(fl);
   endfunction

   function automatic logic [31:0] ref_sample(input logic [41:0] s);
      return {ref_round(s[41:21]), ref_round(s[20:0])};
   endfunction

   function automatic logic [41:0] rand42();
      return 42'({$urandom(), $urandom()});
   endfunction

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_ce = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic drive_pair(input logic [41:0] l, input logic [41:0] r,
                             input logic s, input bit push);
      i_ce = 1'b1; i_left = l; i_right = r; i_sync = s;
      if (push && (s || m_locked)) begin
         m_idx = s ? 0 : (m_idx + 1) % 2048;
         exp_q.push_back({ref_sample(l), s, m_idx == 2047});
         m_idx = (m_idx + 1) % 2048;
         exp_q.push_back({ref_sample(r), 1'b0, m_idx == 2047});
      end
      if (s) m_locked = 1'b1;
      cyc();
      i_ce = 1'b0; i_sync = 1'b0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0;
      repeat (2) cyc();
      i_reset = 1'b0;
      exp_q.delete(); obs_q.delete();
      m_locked = 1'b0; m_idx = 0;
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      i_ce = 1'b0;
      while ((obs_q.size() < exp_q.size() || o_valid) && n < maxc) begin
         cyc(); n++;
      end
      repeat (2) cyc();
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", o_valid); end
      n_chk++; if (o_first !== 1'b0) begin n_err++; $display("FAIL reset_first got %b exp 0", o_first); end
      n_chk++; if (o_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", o_last); end
      n_chk++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b exp 0", o_locked); end
      n_chk++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
   endtask

   task automatic test_lock();
      bit seen = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_pair(rand42(), rand42(), 1'b0, 1'b1);
         if (o_valid || o_locked) seen = 1'b1;
         cyc();
         if (o_valid || o_locked) seen = 1'b1;
      end
      repeat (3) begin cyc(); if (o_valid) seen = 1'b1; end
      n_chk++; if (seen !== 1'b0) begin n_err++; $display("FAIL prelock_output got %b exp 0", seen); end
      drive_pair(rand42(), rand42(), 1'b1, 1'b1);
      n_chk++; if (o_locked !== 1'b1) begin n_err++; $display("FAIL lock_set got %b exp 1", o_locked); end
      n_chk++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lock_lat0 got %b exp 0", o_valid); end
      cyc();
      n_chk++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL lock_lat1 got %b exp 0", o_valid); end
      cyc();
      n_chk++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL lock_lat2_valid got %b exp 1", o_valid); end
      n_chk++; if (o_first !== 1'b1) begin n_err++; $display("FAIL lock_lat2_first got %b exp 1", o_first); end
      n_chk++; if (o_data !== exp_q[0][33:2]) begin n_err++; $display("FAIL lock_data got %h exp %h", o_data, exp_q[0][33:2]); end
      wait_drain(50);
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL lock_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL lock_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_rounding();
      logic [20:0] vin [6]  = '{21'h20, 21'h30, 21'h10, 21'h50, 21'h0FFFFF, 21'h1FFFF0};
      logic [15:0] vout [6] = '{16'h1, 16'h2, 16'h0, 16'h2, 16'h7FFF, 16'h0};
      i_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_pair({vin[i], 21'($urandom)}, {vin[(i+3)%6], 21'($urandom)}, 1'b0, 1'b1);
         idle(1);
      end
      wait_drain(100);
      n_chk++; if (obs_q.size() != 12) begin n_err++; $display("FAIL round_count got %0d exp 12", obs_q.size()); end
      for (int i = 0; i < 6 && 2*i+1 < obs_q.size(); i++) begin
         n_chk++; if (obs_q[2*i][33:18] !== vout[i]) begin n_err++; $display("FAIL round_left[%0d] got %h exp %h", i, obs_q[2*i][33:18], vout[i]); end
         n_chk++; if (obs_q[2*i+1][33:18] !== vout[(i+3)%6]) begin n_err++; $display("FAIL round_right[%0d] got %h exp %h", i, obs_q[2*i+1][33:18], vout[(i+3)%6]); end
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL round_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_full_frame();
      int nf = 0, nl = 0;
      do_reset();
      i_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         drive_pair(rand42(), rand42(), i == 0, 1'b1);
         idle(1);
      end
      wait_drain(100);
      n_chk++; if (obs_q.size() != 2048) begin n_err++; $display("FAIL frame_count got %0d exp 2048", obs_q.size()); end
      foreach (obs_q[k]) begin nf += obs_q[k][1]; nl += obs_q[k][0]; end
      n_chk++; if (obs_q.size() > 0 && obs_q[0][1] !== 1'b1) begin n_err++; $display("FAIL frame_first got %b exp 1", obs_q[0][1]); end
      n_chk++; if (obs_q.size() == 2048 && obs_q[2047][0] !== 1'b1) begin n_err++; $display("FAIL frame_last got %b exp 1", obs_q[2047][0]); end
      n_chk++; if (nf != 1 || nl != 1) begin n_err++; $display("FAIL frame_flag_count got %0d/%0d exp 1/1", nf, nl); end
      n_chk++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL frame_overflow got %b exp 0", o_overflow); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL frame_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overflow();
      do_reset();
      i_ready = 1'b0;
      // One pair sits in the output stage, 32 fill the FIFO.
      for (int i = 0; i < 33; i++)
         drive_pair(rand42(), rand42(), i == 0, 1'b1);
      idle(3);
      n_chk++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got %b exp 0", o_overflow); end
      drive_pair(rand42(), rand42(), 1'b0, 1'b0);
      idle(2);
      n_chk++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", o_overflow); end
      i_ready = 1'b1;
      wait_drain(200);
      n_chk++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
      n_chk++; if (obs_q.size() != 66) begin n_err++; $display("FAIL ovf_count got %0d exp 66", obs_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL ovf_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
      do_reset();
      n_chk++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got %b exp 0", o_overflow); end
   endtask

   task automatic test_stall();
      int n = 0;
      do_reset();
      i_ready = 1'b0;
      drive_pair(rand42(), rand42(), 1'b1, 1'b1);
      while (!o_valid && n < 10) begin cyc(); n++; end
      for (int i = 0; i < 7; i++) begin
         n_chk++; if ({o_data, o_first, o_last} !== {exp_q[0][33:2], 2'b10}) begin
            n_err++; $display("FAIL stall_hold[%0d] got %h/%b/%b exp %h/1/0", i, o_data, o_first, o_last, exp_q[0][33:2]);
         end
         cyc();
      end
      i_ready = 1'b1;
      cyc();
      n_chk++; if (o_data !== exp_q[1][33:2] || o_first !== 1'b0) begin
         n_err++; $display("FAIL stall_release got %h/%b exp %h/0", o_data, o_first, exp_q[1][33:2]);
      end
      wait_drain(20);
      n_chk++; if (obs_q.size() != 2) begin n_err++; $display("FAIL stall_count got %0d exp 2", obs_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stall_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_midframe();
      bit seen = 1'b0;
      do_reset();
      i_ready = 1'b1;
      drive_pair(rand42(), rand42(), 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         drive_pair(rand42(), rand42(), 1'b0, 1'b1);
      i_reset = 1'b1;
      cyc();
      n_chk++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", o_valid); end
      n_chk++; if (o_locked !== 1'b0) begin n_err++; $display("FAIL midrst_locked got %b exp 0", o_locked); end
      i_reset = 1'b0;
      exp_q.delete(); obs_q.delete();
      m_locked = 1'b0; m_idx = 0;
      for (int i = 0; i < 3; i++) begin
         drive_pair(rand42(), rand42(), 1'b0, 1'b1);
         if (o_valid) seen = 1'b1;
         cyc();
         if (o_valid) seen = 1'b1;
      end
      repeat (3) begin cyc(); if (o_valid) seen = 1'b1; end
      n_chk++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_relock_wait got %b exp 0", seen); end
      drive_pair(rand42(), rand42(), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         drive_pair(rand42(), rand42(), 1'b0, 1'b1);
      end
      wait_drain(50);
      n_chk++; if (obs_q.size() != 8) begin n_err++; $display("FAIL midrst_count got %0d exp 8", obs_q.size()); end
      n_chk++; if (obs_q.size() > 0 && obs_q[0][1] !== 1'b1) begin n_err++; $display("FAIL midrst_first got %b exp 1", obs_q[0][1]); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_chk++; if (obs_q[k] !== exp_q[k]) begin n_err++; $display("FAIL midrst_beat[%0d] got %h exp %h", k, obs_q[k], exp_q[k]); end
      end
   endtask

   initial begin
      i_reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_ready = 1'b1;
      i_left = '0; i_right = '0;
      m_locked = 1'b0; m_idx = 0;
      test_reset();
      test_lock();
      test_rounding();
      test_full_frame();
      test_overflow();
      test_stall();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
